// File: rtl/adc_control_pio_pkg.sv
// adc_control_pio_pkg
//   Shared constants and types for the ADC control/status PIO.
//   - ADDR_W          : width of the Avalon-MM word address
//   - ADDR_*          : register word offsets
//   - CNT_W           : width of the pulse length counter
//   - pulse_state_e   : pulse generator state
package adc_control_pio_pkg;

  localparam int unsigned ADDR_W = 3;

  localparam logic [ADDR_W-1:0] ADDR_DATA     = 3'd0;
  localparam logic [ADDR_W-1:0] ADDR_STATUS   = 3'd1;
  localparam logic [ADDR_W-1:0] ADDR_SET      = 3'd2;
  localparam logic [ADDR_W-1:0] ADDR_CLEAR    = 3'd3;
  localparam logic [ADDR_W-1:0] ADDR_PULSE    = 3'd4;
  localparam logic [ADDR_W-1:0] ADDR_EDGE     = 3'd5;
  localparam logic [ADDR_W-1:0] ADDR_IRQ_MASK = 3'd6;

  localparam int unsigned CNT_W = 16;

  typedef enum logic {
    PULSE_IDLE,
    PULSE_ACTIVE
  } pulse_state_e;

endpackage

// File: rtl/adc_control_pio_sync.sv
// adc_control_pio_sync
//   Multi-stage flop synchroniser for a bus of independent asynchronous bits.
//   Each bit is synchronised on its own; no coherency between bits is implied.
// Ports:
//   clk   - destination clock
//   reset - synchronous active-high reset, clears every stage to 0
//   d     - asynchronous input bits
//   q     - synchronised output (last stage)
module adc_control_pio_sync #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] stage_q [STAGES];
  logic [WIDTH-1:0] stage_d [STAGES];

  always_comb begin
    stage_d[0] = d;
    for (int unsigned i = 1; i < STAGES; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < STAGES; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign q = stage_q[STAGES-1];

endmodule

// File: rtl/adc_control_pio.sv
// adc_control_pio
//   Avalon-MM control/status port for the ADC front end.
//   Register map (word offsets):
//     0 DATA      rw   control word
//     1 STATUS    ro   synchronised in_port
//     2 SET       wo   DATA |= wd      (reads 0)
//     3 CLEAR     wo   DATA &= ~wd     (reads 0)
//     4 PULSE     wo   self-timed pulse bits (reads active pulse mask)
//     5 EDGE      rw1c rising-edge capture of synchronised in_port
//     6 IRQ_MASK  rw   interrupt enables for EDGE
//     7 reserved       reads 0, writes ignored
// Ports:
//   clk, reset  - single clock, synchronous active-high reset
//   address     - word address
//   chipselect  - slave select
//   write_n     - active-low write strobe
//   writedata   - write data
//   readdata    - combinational read data, zero-extended
//   in_port     - asynchronous status inputs
//   out_port    - control outputs (DATA | active pulse mask)
//   irq         - level interrupt, |(EDGE & IRQ_MASK)
module adc_control_pio
  import adc_control_pio_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH   = 8,
  parameter int unsigned           IN_WIDTH     = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE  = '0,
  parameter int unsigned           PULSE_CYCLES = 16,
  parameter int unsigned           SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_W-1:0]     address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  input  logic [IN_WIDTH-1:0]   in_port,
  output logic [DATA_WIDTH-1:0] out_port,
  output logic                  irq
);

  localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES);

  logic                  wr;
  logic [DATA_WIDTH-1:0] wd_data;
  logic [IN_WIDTH-1:0]   wd_in;
  logic                  pulse_wr;
  logic                  unused_wd;

  logic [IN_WIDTH-1:0]   status_sync;
  logic [IN_WIDTH-1:0]   rise;

  logic [DATA_WIDTH-1:0] data_q,     data_d;
  logic [DATA_WIDTH-1:0] pmask_q,    pmask_d;
  logic [CNT_W-1:0]      cnt_q,      cnt_d;
  pulse_state_e          state_q,    state_d;
  logic [IN_WIDTH-1:0]   edge_q,     edge_d;
  logic [IN_WIDTH-1:0]   irq_mask_q, irq_mask_d;
  logic [IN_WIDTH-1:0]   prev_q,     prev_d;

  assign wr        = chipselect & ~write_n;
  assign wd_data   = writedata[DATA_WIDTH-1:0];
  assign wd_in     = writedata[IN_WIDTH-1:0];
  assign pulse_wr  = wr && (address == ADDR_PULSE) && (wd_data != '0);
  assign unused_wd = ^writedata;

  adc_control_pio_sync #(
    .WIDTH  (IN_WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (in_port),
    .q     (status_sync)
  );

  // prev starts at 0 after reset, so a bit already high at release is
  // reported as one edge once it emerges from the synchroniser.
  assign rise   = status_sync & ~prev_q;
  assign prev_d = status_sync;

  // Control word and interrupt mask.
  always_comb begin
    data_d     = data_q;
    irq_mask_d = irq_mask_q;
    if (wr) begin
      unique case (address)
        ADDR_DATA:     data_d     = wd_data;
        ADDR_SET:      data_d     = data_q | wd_data;
        ADDR_CLEAR:    data_d     = data_q & ~wd_data;
        ADDR_IRQ_MASK: irq_mask_d = wd_in;
        default:       ;
      endcase
    end
  end

  // Edge capture: a rise in the same cycle as a W1C keeps the bit set.
  always_comb begin
    edge_d = edge_q;
    if (wr && (address == ADDR_EDGE)) begin
      edge_d = edge_q & ~wd_in;
    end
    edge_d = edge_d | rise;
  end

  // Pulse generator. The counter holds the number of cycles the mask stays
  // visible including the current one; a write reloads it (retrigger) and
  // ORs into the mask still shown this cycle, even if this is its last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pmask_d = pmask_q;
    unique case (state_q)
      PULSE_IDLE: ;
      PULSE_ACTIVE: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = PULSE_IDLE;
          cnt_d   = '0;
          pmask_d = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = PULSE_IDLE;
        cnt_d   = '0;
        pmask_d = '0;
      end
    endcase
    if (pulse_wr) begin
      state_d = PULSE_ACTIVE;
      cnt_d   = PULSE_LOAD;
      pmask_d = pmask_q | wd_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q     <= RESET_VALUE;
      pmask_q    <= '0;
      cnt_q      <= '0;
      state_q    <= PULSE_IDLE;
      edge_q     <= '0;
      irq_mask_q <= '0;
      prev_q     <= '0;
    end else begin
      data_q     <= data_d;
      pmask_q    <= pmask_d;
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      edge_q     <= edge_d;
      irq_mask_q <= irq_mask_d;
      prev_q     <= prev_d;
    end
  end

  assign out_port = data_q | pmask_q;
  assign irq      = |(edge_q & irq_mask_q);

  always_comb begin
    readdata = '0;
    unique case (address)
      ADDR_DATA:     readdata[DATA_WIDTH-1:0] = data_q;
      ADDR_STATUS:   readdata[IN_WIDTH-1:0]   = status_sync;
      ADDR_PULSE:    readdata[DATA_WIDTH-1:0] = pmask_q;
      ADDR_EDGE:     readdata[IN_WIDTH-1:0]   = edge_q;
      ADDR_IRQ_MASK: readdata[IN_WIDTH-1:0]   = irq_mask_q;
      default:       ;
    endcase
  end

endmodule

// File: tb/tb_adc_control_pio.sv
// Testbench for adc_control_pio (DATA_WIDTH=8, IN_WIDTH=8, RESET_VALUE=8'hA5,
// PULSE_CYCLES=16, SYNC_STAGES=2). Inputs change on the falling edge; outputs
// are compared 1 time unit later, before the next rising edge.
module tb_adc_control_pio;

  localparam int          PC = 16;
  localparam int          SS = 2;
  localparam logic [7:0]  RV = 8'hA5;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [7:0]  in_port;
  logic [7:0]  out_port;
  logic        irq;

  always #5 clk = ~clk;

  adc_control_pio #(
    .DATA_WIDTH   (8),
    .IN_WIDTH     (8),
    .RESET_VALUE  (RV),
    .PULSE_CYCLES (PC),
    .SYNC_STAGES  (SS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .out_port   (out_port),
    .irq        (irq)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Time is counted in rising edges. in_log[k] holds in_port as sampled at
  // edge k; the synchronised view after edge t is the sample from edge
  // t-SS+1. Pulse bits are visible after edges write_k .. write_k+PC-1.
  int         cyc = 0;
  int         rst_at = 0;
  logic       m_valid = 1'b0;
  logic [7:0] in_log [0:8191];
  logic [7:0] m_data, m_acc, m_edge, m_mask;
  int         m_pend = -1;

  function automatic logic [7:0] smp(input int i);
    if (i < 0 || i <= rst_at) return 8'h00;
    return in_log[i];
  endfunction

  function automatic logic [7:0] m_pmask();
    return (cyc <= m_pend) ? m_acc : 8'h00;
  endfunction

  function automatic logic [7:0] m_status();
    return smp(cyc - SS + 1);
  endfunction

  function automatic logic [31:0] m_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'h0, m_data};
      3'd1:    return {24'h0, m_status()};
      3'd4:    return {24'h0, m_pmask()};
      3'd5:    return {24'h0, m_edge};
      3'd6:    return {24'h0, m_mask};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_clock();
    int k;
    logic [7:0] wd, rise, prior;
    logic wr;
    k = cyc + 1;
    if (reset) begin
      m_data  = RV;
      m_acc   = 8'h00;
      m_pend  = -1;
      m_edge  = 8'h00;
      m_mask  = 8'h00;
      rst_at  = k;
      m_valid = 1'b1;
    end else if (m_valid) begin
      in_log[k] = in_port;
      rise  = smp(k - SS) & ~smp(k - SS - 1);
      wr    = chipselect & ~write_n;
      wd    = writedata[7:0];
      prior = m_pmask();
      if (wr) begin
        case (address)
          3'd0: m_data = wd;
          3'd2: m_data = m_data | wd;
          3'd3: m_data = m_data & ~wd;
          3'd4: if (wd != 8'h00) begin
                  m_acc  = prior | wd;
                  m_pend = k + PC - 1;
                end
          3'd5: m_edge = m_edge & ~wd;
          3'd6: m_mask = wd;
          default: ;
        endcase
      end
      m_edge = m_edge | rise;
    end
    cyc = k;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic r, input logic cs, input logic wn, input logic [2:0] a,
                        input logic [31:0] wd, input logic [7:0] ip);
    reset      = r;
    chipselect = cs;
    write_n    = wn;
    address    = a;
    writedata  = wd;
    in_port    = ip;
    #1;
    if (m_valid) begin
      chk("model_out_port", {24'h0, out_port}, {24'h0, m_data | m_pmask()});
      chk("model_irq", {31'h0, irq}, {31'h0, |(m_edge & m_mask)});
      chk("model_readdata", readdata, m_read(a));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] wd, input logic [7:0] ip);
    set_in(1'b0, 1'b1, 1'b0, a, wd, ip);
  endtask

  task automatic rd_reg(input logic [2:0] a, input logic [7:0] ip);
    set_in(1'b0, 1'b1, 1'b1, a, 32'h0, ip);
  endtask

  typedef struct {
    logic        cs;
    logic        wn;
    logic [2:0]  addr;
    logic [31:0] wd;
    logic [7:0]  e_out;
    logic        e_irq;
    logic [31:0] e_rd;
  } vec_t;

  vec_t tbl [9];

  initial begin
    logic [7:0] exp8;
    logic [7:0] ip;

    // Expected values are those observed while the row is applied,
    // i.e. the effect of the previous rows.
    tbl[0] = '{1'b1, 1'b1, 3'd0, 32'h0,  8'hA5, 1'b0, 32'h0000_00A5};
    tbl[1] = '{1'b1, 1'b0, 3'd0, 32'h0F, 8'hA5, 1'b0, 32'h0000_00A5};
    tbl[2] = '{1'b1, 1'b0, 3'd2, 32'hF0, 8'h0F, 1'b0, 32'h0};
    tbl[3] = '{1'b1, 1'b0, 3'd3, 32'h03, 8'hFF, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 1'b1, 3'd0, 32'h0,  8'hFC, 1'b0, 32'h0000_00FC};
    tbl[5] = '{1'b1, 1'b1, 3'd7, 32'h0,  8'hFC, 1'b0, 32'h0};
    tbl[6] = '{1'b1, 1'b0, 3'd1, 32'hFF, 8'hFC, 1'b0, 32'h0};
    tbl[7] = '{1'b1, 1'b0, 3'd7, 32'hFF, 8'hFC, 1'b0, 32'h0};
    tbl[8] = '{1'b1, 1'b1, 3'd0, 32'h0,  8'hFC, 1'b0, 32'h0000_00FC};

    @(negedge clk);
    set_in(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 8'h00);
    tick();

    // Register access table.
    for (int i = 0; i < 9; i++) begin
      set_in(1'b0, tbl[i].cs, tbl[i].wn, tbl[i].addr, tbl[i].wd, 8'h00);
      chk($sformatf("tbl%0d_out", i), {24'h0, out_port}, {24'h0, tbl[i].e_out});
      chk($sformatf("tbl%0d_irq", i), {31'h0, irq}, {31'h0, tbl[i].e_irq});
      chk($sformatf("tbl%0d_rd", i), readdata, tbl[i].e_rd);
      tick();
    end

    wr_reg(3'd0, 32'h0, 8'h00);
    tick();

    // Single pulse: high for exactly PC cycles.
    for (int j = 0; j <= PC + 2; j++) begin
      if (j == 0) wr_reg(3'd4, 32'h04, 8'h00);
      else        rd_reg(3'd4, 8'h00);
      exp8 = (j >= 1 && j <= PC) ? 8'h04 : 8'h00;
      chk($sformatf("pulse1_out_%0d", j), {24'h0, out_port}, {24'h0, exp8});
      chk($sformatf("pulse1_rd_%0d", j), readdata, {24'h0, exp8});
      tick();
    end

    // Retrigger at cycle 10 extends both bits to 10+PC.
    for (int j = 0; j <= 30; j++) begin
      if (j == 0)       wr_reg(3'd4, 32'h01, 8'h00);
      else if (j == 10) wr_reg(3'd4, 32'h02, 8'h00);
      else              rd_reg(3'd4, 8'h00);
      exp8 = ((j >= 1 && j <= 10 + PC) ? 8'h01 : 8'h00) |
             ((j >= 11 && j <= 10 + PC) ? 8'h02 : 8'h00);
      chk($sformatf("pulse2_out_%0d", j), {24'h0, out_port}, {24'h0, exp8});
      tick();
    end

    // Edge capture and interrupt.
    wr_reg(3'd6, 32'h08, 8'h00);
    tick();
    rd_reg(3'd1, 8'h08);
    chk("edge_status0", readdata, 32'h0);
    tick();
    rd_reg(3'd1, 8'h08);
    chk("edge_status1", readdata, 32'h0);
    tick();
    rd_reg(3'd1, 8'h08);
    chk("edge_status2", readdata, 32'h08);
    chk("edge_irq2", {31'h0, irq}, 32'h0);
    tick();
    rd_reg(3'd5, 8'h08);
    chk("edge_reg3", readdata, 32'h08);
    chk("edge_irq3", {31'h0, irq}, 32'h1);
    tick();
    wr_reg(3'd5, 32'h08, 8'h08);
    chk("edge_irq4", {31'h0, irq}, 32'h1);
    tick();
    rd_reg(3'd5, 8'h08);
    chk("edge_w1c_reg", readdata, 32'h0);
    chk("edge_w1c_irq", {31'h0, irq}, 32'h0);
    tick();

    // W1C coinciding with a new rise: the bit stays set.
    for (int j = 0; j <= 8; j++) begin
      ip = (j == 3 || j >= 5) ? 8'h08 : 8'h00;
      if (j == 7) wr_reg(3'd5, 32'h08, ip);
      else        rd_reg(3'd5, ip);
      chk($sformatf("sim_edge_%0d", j), readdata, (j >= 6) ? 32'h08 : 32'h0);
      chk($sformatf("sim_irq_%0d", j), {31'h0, irq}, (j >= 6) ? 32'h1 : 32'h0);
      tick();
    end

    // Reset during an active pulse with EDGE set.
    wr_reg(3'd4, 32'hFF, 8'h08);
    tick();
    rd_reg(3'd4, 8'h08);
    chk("rst_pulse_active", {24'h0, out_port}, 32'hFF);
    chk("rst_irq_before", {31'h0, irq}, 32'h1);
    tick();
    set_in(1'b1, 1'b0, 1'b1, 3'd0, 32'h0, 8'h08);
    tick();
    rd_reg(3'd5, 8'h08);
    chk("rst_out", {24'h0, out_port}, {24'h0, RV});
    chk("rst_irq", {31'h0, irq}, 32'h0);
    chk("rst_edge", readdata, 32'h0);
    tick();
    rd_reg(3'd4, 8'h08);
    chk("rst_pmask", readdata, 32'h0);
    tick();
    rd_reg(3'd5, 8'h08);
    chk("rst_edge_fill", readdata, 32'h0);
    tick();
    rd_reg(3'd5, 8'h08);
    chk("rst_edge_late", readdata, 32'h08);
    tick();
    rd_reg(3'd7, 8'h08);
    chk("rst_addr7", readdata, 32'h0);
    tick();

    // Randomised traffic against the model.
    ip = 8'h08;
    for (int n = 0; n < 800; n++) begin
      logic        r, cs, wn;
      logic [2:0]  a;
      logic [31:0] wd;
      r  = ($urandom_range(0, 99) == 0);
      cs = ($urandom_range(0, 3) != 0);
      wn = $urandom_range(0, 1);
      a  = 3'($urandom_range(0, 7));
      wd = $urandom;
      if ($urandom_range(0, 3) == 0) wd = 32'(1) << $urandom_range(0, 7);
      if ($urandom_range(0, 7) == 0) wd = 32'h0;
      if ($urandom_range(0, 5) == 0) ip = 8'($urandom);
      set_in(r, cs, wn, a, wd, ip);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
